w5300_udp_rx: RTL and testbench



---
 rtl/w5300_udp_rx.sv | 219 +++++++++++++++++++++
 tb/tb_w5300_udp_rx.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/w5300_udp_rx.sv
// W5300 socket-n UDP receive engine.
// Polls RX_RSR, drains one UDP packet (8-byte header + payload) from RX_FIFOR
// into an external word buffer, reports the peer and length, then issues RECV.
module w5300_udp_rx #(
    parameter int N                    = 0,
    parameter int RX_BUFFER_ADDR_WIDTH = 12,
    parameter int POLL_CYCLES          = 1000
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            sock_ready,
    output logic                            bus_req,
    input  logic                            bus_gnt,
    output logic [11:0]                     caddr,
    output logic [15:0]                     wr_data,
    input  logic [15:0]                     rd_data,
    input  logic                            op_status,
    output logic [15:0]                     rx_data,
    output logic [RX_BUFFER_ADDR_WIDTH-1:0] rx_buffer_addr,
    output logic                            rx_we,
    output logic [31:0]                     peer_ip,
    output logic [15:0]                     peer_port,
    output logic [15:0]                     pkt_len,
    output logic                            pkt_valid,
    output logic                            overflow,
    output logic                            busy_n
);

    localparam logic [9:0]  BASE      = 10'h200 + 10'(N) * 10'h40;
    localparam logic [9:0]  A_RSR_HI  = BASE + 10'h28;
    localparam logic [9:0]  A_RSR_LO  = BASE + 10'h2A;
    localparam logic [9:0]  A_FIFOR   = BASE + 10'h30;
    localparam logic [9:0]  A_CR      = BASE + 10'h02;
    localparam logic [15:0] CMD_RECV  = 16'h0040;
    localparam logic [11:0] CADDR_IDLE = 12'hC00;
    localparam logic [16:0] DEPTH     = 17'd1 << RX_BUFFER_ADDR_WIDTH;
    localparam logic [31:0] POLL_LAST = 32'(POLL_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_POLL_WAIT, S_RSR_HI, S_RSR_LO, S_HDR, S_DATA, S_RECV, S_DONE
    } state_t;

    state_t                          state_q;
    logic [31:0]                     timer_q;
    logic [15:0]                     idx_q;
    logic [15:0]                     words_q;
    logic                            rsr_hi_q;
    logic [11:0]                     caddr_q;
    logic [15:0]                     wr_data_q;
    logic [15:0]                     rx_data_q;
    logic [RX_BUFFER_ADDR_WIDTH-1:0] rx_addr_q;
    logic                            rx_we_q;
    logic [31:0]                     peer_ip_q;
    logic [15:0]                     peer_port_q;
    logic [15:0]                     pkt_len_q;
    logic                            pkt_valid_q;
    logic                            overflow_q;
    logic                            bus_req_q;
    logic                            busy_n_q;

    logic       acc_state;
    logic       acc_rd;
    logic [9:0] acc_addr;
    logic       acc_done;

    // Register address and direction of the access the current state needs.
    always_comb begin
        acc_state = 1'b1;
        acc_rd    = 1'b1;
        acc_addr  = A_FIFOR;
        case (state_q)
            S_RSR_HI: acc_addr = A_RSR_HI;
            S_RSR_LO: acc_addr = A_RSR_LO;
            S_HDR,
            S_DATA:   acc_addr = A_FIFOR;
            S_RECV: begin
                acc_rd   = 1'b0;
                acc_addr = A_CR;
            end
            default:  acc_state = 1'b0;
        endcase
    end

    // An access completes when op_status arrives while our address is valid.
    assign acc_done = !caddr_q[11] && op_status;

    // Main FSM plus bus access sequencing; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            idx_q       <= '0;
            words_q     <= '0;
            rsr_hi_q    <= 1'b0;
            caddr_q     <= CADDR_IDLE;
            wr_data_q   <= '0;
            rx_data_q   <= '0;
            rx_addr_q   <= '0;
            rx_we_q     <= 1'b0;
            peer_ip_q   <= '0;
            peer_port_q <= '0;
            pkt_len_q   <= '0;
            pkt_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            bus_req_q   <= 1'b0;
            busy_n_q    <= 1'b1;
        end else begin
            rx_we_q     <= 1'b0;
            pkt_valid_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (sock_ready) begin
                        state_q  <= S_POLL_WAIT;
                        timer_q  <= '0;
                        busy_n_q <= 1'b0;
                    end
                end
                S_POLL_WAIT: begin
                    if (!sock_ready) begin
                        state_q  <= S_IDLE;
                        busy_n_q <= 1'b1;
                    end else if (timer_q == POLL_LAST) begin
                        state_q   <= S_RSR_HI;
                        bus_req_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 32'd1;
                    end
                end
                S_RSR_HI: begin
                    if (acc_done) begin
                        rsr_hi_q <= rd_data[0];
                        state_q  <= S_RSR_LO;
                    end
                end
                S_RSR_LO: begin
                    if (acc_done) begin
                        if ({rsr_hi_q, rd_data} == 17'd0) begin
                            state_q   <= S_POLL_WAIT;
                            timer_q   <= '0;
                            bus_req_q <= 1'b0;
                        end else begin
                            state_q <= S_HDR;
                            idx_q   <= '0;
                        end
                    end
                end
                S_HDR: begin
                    if (acc_done) begin
                        idx_q <= idx_q + 16'd1;
                        case (idx_q[1:0])
                            2'd0: peer_ip_q[31:16] <= rd_data;
                            2'd1: peer_ip_q[15:0]  <= rd_data;
                            2'd2: peer_port_q      <= rd_data;
                            default: begin
                                // Payload is packed two bytes per word, odd sizes padded.
                                pkt_len_q <= rd_data;
                                words_q   <= 16'((17'(rd_data) + 17'd1) >> 1);
                                idx_q     <= '0;
                                state_q   <= (rd_data == 16'd0) ? S_RECV : S_DATA;
                            end
                        endcase
                    end
                end
                S_DATA: begin
                    if (acc_done) begin
                        // Words past the buffer are still read so the FIFO drains.
                        if ({1'b0, idx_q} < DEPTH) begin
                            rx_data_q <= rd_data;
                            rx_addr_q <= idx_q[RX_BUFFER_ADDR_WIDTH-1:0];
                            rx_we_q   <= 1'b1;
                        end else begin
                            overflow_q <= 1'b1;
                        end
                        idx_q <= idx_q + 16'd1;
                        if (idx_q == words_q - 16'd1) begin
                            state_q <= S_RECV;
                        end
                    end
                end
                S_RECV: begin
                    if (acc_done) begin
                        state_q     <= S_DONE;
                        pkt_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= S_POLL_WAIT;
                    timer_q   <= '0;
                    bus_req_q <= 1'b0;
                end
            endcase

            // Completion drops valid for one gap cycle; the next access may start right after.
            if (acc_state) begin
                if (acc_done) begin
                    caddr_q <= CADDR_IDLE;
                end else if (caddr_q[11] && bus_gnt) begin
                    caddr_q   <= {1'b0, acc_rd, acc_addr};
                    wr_data_q <= acc_rd ? 16'h0000 : CMD_RECV;
                end
            end
        end
    end

    assign bus_req        = bus_req_q;
    assign caddr          = caddr_q;
    assign wr_data        = wr_data_q;
    assign rx_data        = rx_data_q;
    assign rx_buffer_addr = rx_addr_q;
    assign rx_we          = rx_we_q;
    assign peer_ip        = peer_ip_q;
    assign peer_port      = peer_port_q;
    assign pkt_len        = pkt_len_q;
    assign pkt_valid      = pkt_valid_q;
    assign overflow       = overflow_q;
    assign busy_n         = busy_n_q;

endmodule

// File: tb/tb_w5300_udp_rx.sv
// Directed bench for w5300_udp_rx: a small W5300 bus model answers register
// and FIFO reads, monitors log RX buffer writes and packet pulses.
module tb_w5300_udp_rx;
    localparam int AW  = 2;
    localparam int PC  = 8;
    localparam int LAT = 1;

    logic          clk, rst_n, sock_ready, bus_req, bus_gnt;
    logic [11:0]   caddr;
    logic [15:0]   wr_data, rd_data, rx_data, peer_port, pkt_len;
    logic          op_status, rx_we, pkt_valid, overflow, busy_n;
    logic [AW-1:0] rx_buffer_addr;
    logic [31:0]   peer_ip;

    w5300_udp_rx #(.N(0), .RX_BUFFER_ADDR_WIDTH(AW), .POLL_CYCLES(PC)) dut (
        .clk(clk), .rst_n(rst_n), .sock_ready(sock_ready),
        .bus_req(bus_req), .bus_gnt(bus_gnt), .caddr(caddr),
        .wr_data(wr_data), .rd_data(rd_data), .op_status(op_status),
        .rx_data(rx_data), .rx_buffer_addr(rx_buffer_addr), .rx_we(rx_we),
        .peer_ip(peer_ip), .peer_port(peer_port), .pkt_len(pkt_len),
        .pkt_valid(pkt_valid), .overflow(overflow), .busy_n(busy_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // W5300 model state and access / output logs.
    logic [31:0] rsr = 32'd0;
    logic [15:0] fifo[$];
    logic [11:0] acc_q[$];
    logic [15:0] accw_q[$];
    int          acct_q[$];
    int          rxa_q[$];
    logic [15:0] rxd_q[$];
    int          pv_cnt = 0;
    logic [31:0] pv_ip;
    logic [15:0] pv_port, pv_len;

    // Bus model: op_status LAT cycles after caddr becomes valid.
    initial begin
        int cnt;
        cnt = 0;
        op_status = 1'b0;
        rd_data = 16'h0;
        forever begin
            @(negedge clk);
            if (op_status) begin
                op_status = 1'b0;
                cnt = 0;
            end else if (rst_n && !caddr[11]) begin
                cnt++;
                if (cnt == LAT + 1) begin
                    cnt = 0;
                    op_status = 1'b1;
                    acc_q.push_back(caddr);
                    accw_q.push_back(wr_data);
                    acct_q.push_back(cyc);
                    if (caddr[10]) begin
                        case (caddr[9:0])
                            10'h228: rd_data = rsr[31:16];
                            10'h22A: rd_data = rsr[15:0];
                            10'h230: begin
                                if (fifo.size() > 0) rd_data = fifo.pop_front();
                                else rd_data = 16'hDEAD;
                            end
                            default: rd_data = 16'h0;
                        endcase
                    end else if (caddr[9:0] == 10'h202 && wr_data == 16'h0040) begin
                        rsr = 32'd0;
                    end
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Output monitor, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (rx_we) begin
                rxa_q.push_back(int'(rx_buffer_addr));
                rxd_q.push_back(rx_data);
            end
            if (pkt_valid) begin
                pv_cnt++;
                pv_ip = peer_ip;
                pv_port = peer_port;
                pv_len = pkt_len;
            end
        end
    end

    task automatic clear_logs();
        acc_q.delete(); accw_q.delete(); acct_q.delete();
        rxa_q.delete(); rxd_q.delete();
    endtask

    task automatic count_acc(input logic [11:0] ca, output int n);
        n = 0;
        foreach (acc_q[i]) if (acc_q[i] == ca) n++;
    endtask

    task automatic cr_write(output int n, output logic [15:0] d);
        n = 0;
        d = 16'h0;
        foreach (acc_q[i]) if (acc_q[i] == 12'h202) begin
            n++;
            d = accw_q[i];
        end
    endtask

    task automatic wait_pv(input int maxc);
        int start;
        int k;
        start = pv_cnt;
        k = 0;
        while (pv_cnt == start && k < maxc) begin
            @(negedge clk);
            k++;
        end
        chk("pkt_timeout", 32'(pv_cnt != start), 32'd1);
    endtask

    task automatic load_pkt(input logic [15:0] w0, w1, w2, w3);
        fifo.push_back(w0); fifo.push_back(w1); fifo.push_back(w2); fifo.push_back(w3);
    endtask

    initial begin
        int n, k;
        logic [15:0] d;
        rst_n = 1'b0; sock_ready = 1'b0; bus_gnt = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_caddr", 32'(caddr), 32'h0C00);
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_busy_n", 32'(busy_n), 32'd1);
        chk("rst_outs", {rx_we, pkt_valid, overflow, 29'd0}, 32'd0);
        chk("rst_peer", peer_ip | 32'(peer_port) | 32'(pkt_len), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Empty socket: only RSR polls, 14-cycle period.
        clear_logs();
        sock_ready = 1'b1;
        repeat (60) @(negedge clk);
        chk("poll_n_ge4", 32'(acc_q.size() >= 4), 32'd1);
        chk("poll_hi_addr", 32'(acc_q[0]), 32'h628);
        chk("poll_lo_addr", 32'(acc_q[1]), 32'h62A);
        chk("poll_period", 32'(acct_q[2] - acct_q[0]), 32'd14);
        count_acc(12'h630, n);
        chk("poll_no_fifor", 32'(n), 32'd0);
        chk("poll_no_pv", 32'(pv_cnt), 32'd0);

        // 6-byte packet.
        clear_logs();
        load_pkt(16'hC0A8, 16'h0001, 16'h1F90, 16'h0006);
        fifo.push_back(16'h1122); fifo.push_back(16'h3344); fifo.push_back(16'h5566);
        rsr = 32'd14;
        wait_pv(200);
        chk("p6_rx_n", 32'(rxa_q.size()), 32'd3);
        chk("p6_rx_addr", {8'(rxa_q[0]), 8'(rxa_q[1]), 8'(rxa_q[2]), 8'd0}, 32'h00010200);
        chk("p6_rx_d01", {rxd_q[0], rxd_q[1]}, 32'h11223344);
        chk("p6_rx_d2", 32'(rxd_q[2]), 32'h5566);
        count_acc(12'h630, n);
        chk("p6_fifor_n", 32'(n), 32'd7);
        cr_write(n, d);
        chk("p6_cr_n", 32'(n), 32'd1);
        chk("p6_cr_data", 32'(d), 32'h0040);
        chk("p6_ip", pv_ip, 32'hC0A80001);
        chk("p6_port", 32'(pv_port), 32'h1F90);
        chk("p6_len", 32'(pv_len), 32'd6);
        chk("p6_ovf", 32'(overflow), 32'd0);

        // 5-byte packet: last word padded but written.
        repeat (5) @(negedge clk);
        clear_logs();
        load_pkt(16'hC0A8, 16'h0002, 16'h0035, 16'h0005);
        fifo.push_back(16'hAABB); fifo.push_back(16'hCCDD); fifo.push_back(16'hEE00);
        rsr = 32'd13;
        wait_pv(200);
        chk("p5_rx_n", 32'(rxa_q.size()), 32'd3);
        chk("p5_rx_last", {16'(rxa_q[2]), rxd_q[2]}, 32'h0002EE00);
        count_acc(12'h630, n);
        chk("p5_fifor_n", 32'(n), 32'd7);
        chk("p5_len", 32'(pv_len), 32'd5);
        chk("p5_port", 32'(pv_port), 32'h0035);

        // Zero-length packet: header only, RECV still issued.
        repeat (5) @(negedge clk);
        clear_logs();
        load_pkt(16'h0A00, 16'h0001, 16'h0007, 16'h0000);
        rsr = 32'd8;
        wait_pv(200);
        chk("p0_rx_n", 32'(rxa_q.size()), 32'd0);
        count_acc(12'h630, n);
        chk("p0_fifor_n", 32'(n), 32'd4);
        cr_write(n, d);
        chk("p0_cr_n", 32'(n), 32'd1);
        chk("p0_len_ip", {pv_len, pv_ip[15:0]}, 32'h00000001);

        // 12-byte packet into a 4-word buffer: overflow.
        repeat (5) @(negedge clk);
        clear_logs();
        load_pkt(16'hC0A8, 16'h0003, 16'h0100, 16'h000C);
        for (int i = 1; i <= 6; i++) fifo.push_back(16'(i));
        rsr = 32'd20;
        wait_pv(300);
        chk("ov_rx_n", 32'(rxa_q.size()), 32'd4);
        chk("ov_rx_last", {16'(rxa_q[3]), rxd_q[3]}, 32'h00030004);
        count_acc(12'h630, n);
        chk("ov_fifor_n", 32'(n), 32'd10);
        chk("ov_flag", 32'(overflow), 32'd1);
        cr_write(n, d);
        chk("ov_cr_n", 32'(n), 32'd1);
        chk("ov_fifo_empty", 32'(fifo.size()), 32'd0);

        // Reset during payload transfer.
        repeat (5) @(negedge clk);
        clear_logs();
        load_pkt(16'hC0A8, 16'h0001, 16'h1F90, 16'h0006);
        fifo.push_back(16'h1122); fifo.push_back(16'h3344); fifo.push_back(16'h5566);
        rsr = 32'd14;
        k = 0;
        while (!rx_we && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("mr_saw_data", 32'(rx_we), 32'd1);
        rst_n = 1'b0;
        bus_gnt = 1'b0;
        @(posedge clk);
        #1;
        chk("mr_caddr", 32'(caddr), 32'h0C00);
        chk("mr_req_busy", {30'd0, bus_req, busy_n}, 32'd1);
        chk("mr_rx", {rx_we, pkt_valid, overflow, 13'd0, rx_data}, 32'd0);
        chk("mr_rx_addr", 32'(rx_buffer_addr), 32'd0);
        chk("mr_peer", peer_ip | 32'(peer_port) | 32'(pkt_len), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        fifo.delete();
        rsr = 32'd0;

        // Grant withheld: request rises but no access starts.
        k = 0;
        while (!bus_req && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("gnt_req", 32'(bus_req), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("gnt_hold_vn", 32'(caddr[11]), 32'd1);
        end
        clear_logs();
        bus_gnt = 1'b1;
        k = 0;
        while (acc_q.size() == 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("gnt_first_acc", 32'(acc_q.size() > 0 ? acc_q[0] : 12'hFFF), 32'h628);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end
endmodule
